sys_rx_cmd_ctrl: RTL and testbench
==================================

# sys_rx_cmd_ctrl

Command-frame controller on the UART receive path. It consumes the byte stream from the UART receiver (one `rx_d_valid` pulse per good frame) and decodes two command types: register-file write and register-file read. It sequences the matching register-file strobes and forwards read data to the UART transmitter under a busy handshake. It sits between the UART RX/TX pair and the register file in the system controller.

## Interface
- `DATA_WIDTH`, default 8: byte width of RX, TX and register-file data.
- `ADDR_WIDTH`, default 4: register-file address width; the low `ADDR_WIDTH` bits of the address byte are used.
- `TIMEOUT_CYCLES`, default 1024: inter-byte timeout in clk cycles. Only active with `SYS_RX_TIMEOUT_EN`.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `rx_p_data`, in, DATA_WIDTH: received byte; valid only while `rx_d_valid` is high.
- `rx_d_valid`, in, 1: one-cycle pulse per received byte.
- `rf_rd_data`, in, DATA_WIDTH: register-file read data.
- `rf_rd_valid`, in, 1: read data valid pulse.
- `tx_busy`, in, 1: transmitter busy; a byte cannot be offered while this is high.
- `rf_addr`, out, ADDR_WIDTH: register-file address.
- `rf_wr_data`, out, DATA_WIDTH: write data.
- `rf_wr_en`, out, 1: write strobe, one cycle.
- `rf_rd_en`, out, 1: read strobe, one cycle.
- `tx_p_data`, out, DATA_WIDTH: byte to transmit.
- `tx_d_valid`, out, 1: transmit request, one cycle.
- `cmd_err`, out, 1: pulse on an unknown command byte.
- `ovr_err`, out, 1: pulse when a byte arrives during RD_WAIT or TX_SEND (the byte is dropped).
- `timeout_err`, out, 1: pulse on frame abort due to timeout.

## Operation
States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
- **IDLE**, on `rx_d_valid`:
  - `8'hAA` goes to WR_ADDR.
  - `8'hBB` goes to RD_ADDR.
  - Any other value: pulse `cmd_err` and stay in IDLE.
- **WR_ADDR**, on byte: latch the address and go to WR_DATA.
- **WR_DATA**, on byte: drive `rf_addr` and `rf_wr_data`, pulse `rf_wr_en`, go to IDLE.
- **RD_ADDR**, on byte: latch the address, pulse `rf_rd_en`, go to RD_WAIT.
- **RD_WAIT**, on `rf_rd_valid`: latch `rf_rd_data` into `tx_p_data` and go to TX_SEND. `rf_rd_valid` is ignored in every other state.
- **TX_SEND**, when `tx_busy` is 0: pulse `tx_d_valid` and go to IDLE.
- A byte received in RD_WAIT or TX_SEND is discarded and `ovr_err` pulses. The state is unchanged.
- `rf_addr`, `rf_wr_data` and `tx_p_data` hold their values until the next update.

## Timing
- All outputs are registered.
- Reset value of every output is 0. Reset returns the FSM to IDLE immediately, including mid-frame; a partial frame is discarded.
- `rf_wr_en` is high exactly one cycle, in the cycle after the data byte's `rx_d_valid`. `rf_addr` and `rf_wr_data` are valid in that same cycle.
- `rf_rd_en` is high exactly one cycle, in the cycle after the address byte's `rx_d_valid`.
- `tx_d_valid` is high one cycle, in the cycle after the first TX_SEND cycle with `tx_busy` = 0. If `rf_rd_valid` arrives while `tx_busy` = 0, minimum read-to-send latency is 2 cycles.
- `cmd_err`, `ovr_err` and `timeout_err` each pulse one cycle after their trigger.
- Back-to-back bytes on consecutive cycles are accepted; no gap cycles are required.

## Configuration
- With `SYS_RX_TIMEOUT_EN` defined:
  - In WR_ADDR, WR_DATA and RD_ADDR, a counter clears on entry and on each byte, and increments otherwise.
  - When the count reaches `TIMEOUT_CYCLES-1`, the FSM goes to IDLE and `timeout_err` pulses.
  - If a byte and expiry occur in the same cycle, the byte wins: it is processed and no timeout occurs.
- Without the macro: no counter, the FSM waits indefinitely, and `timeout_err` is tied to 0.

## Structure
- Shared package `sys_ctrl_pkg` holds:
  - `CMD_RF_WR = 8'hAA` and `CMD_RF_RD = 8'hBB`.
  - The state encoding constants.
- Sub-module `sys_frame_timer` implements the timeout counter, with inputs `clear` and `run` and output `expired`. It is instantiated only under `SYS_RX_TIMEOUT_EN`.

## Test plan
- Write: RX bytes AA, 05, 3C → one-cycle `rf_wr_en` with `rf_addr` = 5 and `rf_wr_data` = 8'h3C, one cycle after the 3C pulse; then IDLE.
- Read: RX bytes BB, 0A → `rf_rd_en` with `rf_addr` = 10. Return `rf_rd_data` = 8'h77 with `tx_busy` = 1 for 20 cycles → `tx_d_valid` only after `tx_busy` falls, with `tx_p_data` = 8'h77.
- Unknown command: RX byte 8'h12 → `cmd_err` single pulse, no strobes. A following AA, 01, FF frame then writes normally.
- Overrun: a byte arriving during RD_WAIT → `ovr_err` pulse; the read completes with the correct data.
- Timeout (macro on, `TIMEOUT_CYCLES` = 16): AA then silence → `timeout_err` after 16 cycles, no `rf_wr_en`. Repeat with a byte arriving on the expiry cycle → no abort.
- Reset: assert `rst` between AA and the address byte → all outputs 0; subsequent bytes 05, 3C are decoded from IDLE (05 gives `cmd_err`).

Source files
------------

// File: rtl/sys_ctrl_pkg.sv
// Shared constants for the system controller: command bytes, receive FSM
// state encodings and a helper naming the states covered by the frame timer.
package sys_ctrl_pkg;

   localparam logic [7:0] CMD_RF_WR = 8'hAA;
   localparam logic [7:0] CMD_RF_RD = 8'hBB;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_WR_ADDR = 3'd1;
   localparam logic [2:0] ST_WR_DATA = 3'd2;
   localparam logic [2:0] ST_RD_ADDR = 3'd3;
   localparam logic [2:0] ST_RD_WAIT = 3'd4;
   localparam logic [2:0] ST_TX_SEND = 3'd5;

   // States in which a frame is partially received and can be abandoned.
   function automatic logic is_frame_state(input logic [2:0] st);
      return (st == ST_WR_ADDR) || (st == ST_WR_DATA) || (st == ST_RD_ADDR);
   endfunction

endpackage

// File: rtl/sys_frame_timer.sv
// Inter-byte frame timer: clears on request, counts while running, and flags
// expiry when the count sits at TIMEOUT_CYCLES-1.
module sys_frame_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (run) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign expired = run && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/sys_rx_cmd_ctrl.sv
// UART receive-side command controller: decodes register write/read frames and
// forwards read data to the transmitter. Define SYS_RX_TIMEOUT_EN for the inter-byte timeout.
module sys_rx_cmd_ctrl
   import sys_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned ADDR_WIDTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] rx_p_data,
   input  logic                  rx_d_valid,
   input  logic [DATA_WIDTH-1:0] rf_rd_data,
   input  logic                  rf_rd_valid,
   input  logic                  tx_busy,
   output logic [ADDR_WIDTH-1:0] rf_addr,
   output logic [DATA_WIDTH-1:0] rf_wr_data,
   output logic                  rf_wr_en,
   output logic                  rf_rd_en,
   output logic [DATA_WIDTH-1:0] tx_p_data,
   output logic                  tx_d_valid,
   output logic                  cmd_err,
   output logic                  ovr_err,
   output logic                  timeout_err
);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   logic [2:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_addr_lat;
   logic [ADDR_WIDTH-1:0] r_rf_addr;
   logic [DATA_WIDTH-1:0] r_rf_wr_data;
   logic [DATA_WIDTH-1:0] r_tx_p_data;
   logic                  r_rf_wr_en;
   logic                  r_rf_rd_en;
   logic                  r_tx_d_valid;
   logic                  r_cmd_err;
   logic                  r_ovr_err;
   logic                  r_timeout_err;
   logic                  w_expired;

`ifdef SYS_RX_TIMEOUT_EN
   logic w_tmr_run;
   logic w_tmr_clear;

   // Any accepted byte or any non-frame state restarts the inter-byte window.
   assign w_tmr_run   = is_frame_state(r_state);
   assign w_tmr_clear = rx_d_valid || !w_tmr_run;

   sys_frame_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_frame_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (w_tmr_clear),
      .run     (w_tmr_run),
      .expired (w_expired)
   );
`else
   assign w_expired = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_IDLE;
         r_addr_lat    <= '0;
         r_rf_addr     <= '0;
         r_rf_wr_data  <= '0;
         r_tx_p_data   <= '0;
         r_rf_wr_en    <= 1'b0;
         r_rf_rd_en    <= 1'b0;
         r_tx_d_valid  <= 1'b0;
         r_cmd_err     <= 1'b0;
         r_ovr_err     <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_rf_wr_en    <= 1'b0;
         r_rf_rd_en    <= 1'b0;
         r_tx_d_valid  <= 1'b0;
         r_cmd_err     <= 1'b0;
         r_ovr_err     <= 1'b0;
         r_timeout_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (rx_d_valid) begin
                  if (rx_p_data == DATA_WIDTH'(CMD_RF_WR)) begin
                     r_state <= ST_WR_ADDR;
                  end else if (rx_p_data == DATA_WIDTH'(CMD_RF_RD)) begin
                     r_state <= ST_RD_ADDR;
                  end else begin
                     r_cmd_err <= 1'b1;
                  end
               end
            end
            // In the frame states a byte takes priority over a coincident expiry.
            ST_WR_ADDR: begin
               if (rx_d_valid) begin
                  r_addr_lat <= rx_p_data[ADDR_WIDTH-1:0];
                  r_state    <= ST_WR_DATA;
               end else if (w_expired) begin
                  r_timeout_err <= 1'b1;
                  r_state       <= ST_IDLE;
               end
            end
            ST_WR_DATA: begin
               if (rx_d_valid) begin
                  r_rf_addr    <= r_addr_lat;
                  r_rf_wr_data <= rx_p_data;
                  r_rf_wr_en   <= 1'b1;
                  r_state      <= ST_IDLE;
               end else if (w_expired) begin
                  r_timeout_err <= 1'b1;
                  r_state       <= ST_IDLE;
               end
            end
            ST_RD_ADDR: begin
               if (rx_d_valid) begin
                  r_rf_addr  <= rx_p_data[ADDR_WIDTH-1:0];
                  r_rf_rd_en <= 1'b1;
                  r_state    <= ST_RD_WAIT;
               end else if (w_expired) begin
                  r_timeout_err <= 1'b1;
                  r_state       <= ST_IDLE;
               end
            end
            ST_RD_WAIT: begin
               r_ovr_err <= rx_d_valid;
               if (rf_rd_valid) begin
                  r_tx_p_data <= rf_rd_data;
                  r_state     <= ST_TX_SEND;
               end
            end
            ST_TX_SEND: begin
               r_ovr_err <= rx_d_valid;
               if (!tx_busy) begin
                  r_tx_d_valid <= 1'b1;
                  r_state      <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign rf_addr     = r_rf_addr;
   assign rf_wr_data  = r_rf_wr_data;
   assign rf_wr_en    = r_rf_wr_en;
   assign rf_rd_en    = r_rf_rd_en;
   assign tx_p_data   = r_tx_p_data;
   assign tx_d_valid  = r_tx_d_valid;
   assign cmd_err     = r_cmd_err;
   assign ovr_err     = r_ovr_err;
   assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_sys_rx_cmd_ctrl.sv
// Directed self-checking bench for sys_rx_cmd_ctrl; timeout cases depend on SYS_RX_TIMEOUT_EN.
module tb_sys_rx_cmd_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] rx_p_data = '0;
   logic       rx_d_valid = 1'b0;
   logic [7:0] rf_rd_data = '0;
   logic       rf_rd_valid = 1'b0;
   logic       tx_busy = 1'b0;
   logic [3:0] rf_addr;
   logic [7:0] rf_wr_data;
   logic       rf_wr_en;
   logic       rf_rd_en;
   logic [7:0] tx_p_data;
   logic       tx_d_valid;
   logic       cmd_err;
   logic       ovr_err;
   logic       timeout_err;

   int unsigned n_vec = 0;
   int unsigned n_miss = 0;

   sys_rx_cmd_ctrl #(
      .DATA_WIDTH     (8),
      .ADDR_WIDTH     (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_p_data   (rx_p_data),
      .rx_d_valid  (rx_d_valid),
      .rf_rd_data  (rf_rd_data),
      .rf_rd_valid (rf_rd_valid),
      .tx_busy     (tx_busy),
      .rf_addr     (rf_addr),
      .rf_wr_data  (rf_wr_data),
      .rf_wr_en    (rf_wr_en),
      .rf_rd_en    (rf_rd_en),
      .tx_p_data   (tx_p_data),
      .tx_d_valid  (tx_d_valid),
      .cmd_err     (cmd_err),
      .ovr_err     (ovr_err),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rx_byte(input logic [7:0] b);
      rx_p_data  = b;
      rx_d_valid = 1'b1;
      tick();
      rx_d_valid = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_addr"}, 32'(rf_addr), 32'h0);
      chk({tag, "_wdata"}, 32'(rf_wr_data), 32'h0);
      chk({tag, "_txd"}, 32'(tx_p_data), 32'h0);
      chk({tag, "_strobes"}, {26'b0, rf_wr_en, rf_rd_en, tx_d_valid, cmd_err, ovr_err, timeout_err}, 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;

      #2;
      chk_all_zero("reset");
      tick();
      rst = 1'b1;
      tick();

      // Write AA 05 3C
      rx_byte(8'hAA);
      rx_byte(8'h05);
      chk("wr_en_early", 32'(rf_wr_en), 32'h0);
      rx_byte(8'h3C);
      chk("wr_en", 32'(rf_wr_en), 32'h1);
      chk("wr_addr", 32'(rf_addr), 32'h5);
      chk("wr_data", 32'(rf_wr_data), 32'h3C);
      tick();
      chk("wr_en_one_cycle", 32'(rf_wr_en), 32'h0);
      chk("wr_data_hold", 32'(rf_wr_data), 32'h3C);

      // Read BB 0A with 20 busy cycles
      rx_byte(8'hBB);
      rx_byte(8'h0A);
      chk("rd_en", 32'(rf_rd_en), 32'h1);
      chk("rd_addr", 32'(rf_addr), 32'hA);
      tick();
      chk("rd_en_one_cycle", 32'(rf_rd_en), 32'h0);
      tx_busy     = 1'b1;
      rf_rd_data  = 8'h77;
      rf_rd_valid = 1'b1;
      tick();
      rf_rd_valid = 1'b0;
      rf_rd_data  = 8'h00;
      chk("rd_latch", 32'(tx_p_data), 32'h77);
      seen = tx_d_valid;
      for (int i = 0; i < 19; i++) begin
         tick();
         seen = seen | tx_d_valid;
      end
      chk("tx_held_busy", 32'(seen), 32'h0);
      tx_busy = 1'b0;
      tick();
      chk("tx_valid", 32'(tx_d_valid), 32'h1);
      chk("tx_data", 32'(tx_p_data), 32'h77);
      tick();
      chk("tx_valid_one_cycle", 32'(tx_d_valid), 32'h0);

      // Unknown command then normal write
      rx_byte(8'h12);
      chk("cmd_err", 32'(cmd_err), 32'h1);
      chk("cmd_err_no_strobe", {30'b0, rf_wr_en, rf_rd_en}, 32'h0);
      rx_byte(8'hAA);
      chk("cmd_err_one_cycle", 32'(cmd_err), 32'h0);
      rx_byte(8'h01);
      rx_byte(8'hFF);
      chk("wr2", {20'b0, rf_wr_en, 3'b0, rf_addr, rf_wr_data}, {20'b0, 1'b1, 3'b0, 4'h1, 8'hFF});

      // Overrun during RD_WAIT, read with minimum latency
      rx_byte(8'hBB);
      rx_byte(8'h03);
      chk("rd2", {27'b0, rf_rd_en, rf_addr}, {27'b0, 1'b1, 4'h3});
      rx_byte(8'h55);
      chk("ovr_rdwait", 32'(ovr_err), 32'h1);
      chk("ovr_no_strobe", {30'b0, rf_wr_en, rf_rd_en}, 32'h0);
      tick();
      chk("ovr_one_cycle", 32'(ovr_err), 32'h0);
      rf_rd_data  = 8'h9C;
      rf_rd_valid = 1'b1;
      tick();
      rf_rd_valid = 1'b0;
      chk("rd2_latch", {23'b0, tx_d_valid, tx_p_data}, {23'b0, 1'b0, 8'h9C});
      tick();
      chk("rd2_tx_latency2", 32'(tx_d_valid), 32'h1);

      // Overrun in TX_SEND while busy
      rx_byte(8'hBB);
      rx_byte(8'h04);
      tx_busy     = 1'b1;
      rf_rd_data  = 8'h3E;
      rf_rd_valid = 1'b1;
      tick();
      rf_rd_valid = 1'b0;
      rx_byte(8'hAA);
      chk("ovr_txsend", {30'b0, ovr_err, tx_d_valid}, {30'b0, 1'b1, 1'b0});
      tx_busy = 1'b0;
      tick();
      chk("tx3", {23'b0, tx_d_valid, tx_p_data}, {23'b0, 1'b1, 8'h3E});

      // rf_rd_valid ignored in IDLE
      rf_rd_data  = 8'h11;
      rf_rd_valid = 1'b1;
      tick();
      rf_rd_valid = 1'b0;
      tick();
      tick();
      chk("rdvalid_idle_ignored", {23'b0, tx_d_valid, tx_p_data}, {23'b0, 1'b0, 8'h3E});

`ifdef SYS_RX_TIMEOUT_EN
      rx_byte(8'hAA);
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         seen = seen | timeout_err;
      end
      chk("timeout_early", 32'(seen), 32'h0);
      tick();
      chk("timeout_err", {30'b0, timeout_err, rf_wr_en}, {30'b0, 1'b1, 1'b0});
      rx_byte(8'h05);
      chk("timeout_back_idle", 32'(cmd_err), 32'h1);
      rx_byte(8'hAA);
      for (int i = 0; i < 15; i++) tick();
      rx_byte(8'h07);
      chk("timeout_byte_wins", 32'(timeout_err), 32'h0);
      rx_byte(8'h5A);
      chk("wr_after_edge_byte", {20'b0, rf_wr_en, 3'b0, rf_addr, rf_wr_data}, {20'b0, 1'b1, 3'b0, 4'h7, 8'h5A});
`else
      rx_byte(8'hAA);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         seen = seen | timeout_err;
      end
      chk("no_timeout", 32'(seen), 32'h0);
      rx_byte(8'h07);
      rx_byte(8'h5A);
      chk("wr_after_silence", {20'b0, rf_wr_en, 3'b0, rf_addr, rf_wr_data}, {20'b0, 1'b1, 3'b0, 4'h7, 8'h5A});
`endif

      // Reset mid-frame
      rx_byte(8'hAA);
      rst = 1'b0;
      #2;
      chk_all_zero("midreset");
      tick();
      rst = 1'b1;
      tick();
      rx_byte(8'h05);
      chk("post_reset_cmd_err", 32'(cmd_err), 32'h1);
      rx_byte(8'h3C);
      chk("post_reset_3c", {30'b0, cmd_err, rf_wr_en}, {30'b0, 1'b1, 1'b0});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
